// File: rtl/shared_div_arbiter.sv
// Shared restoring divider time-multiplexed between THREADS requesters.
// A round-robin arbiter picks one requester, which is then served by a three-state FSM.
module shared_div_arbiter #(
  parameter  int THREADS = 4,
  parameter  int WIDTH   = 8,
  localparam int GW      = (THREADS > 1) ? $clog2(THREADS) : 1,
  localparam int CW      = $clog2(WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [THREADS-1:0]         req,
  input  logic [THREADS*WIDTH-1:0]   dividend,
  input  logic [THREADS*WIDTH-1:0]   divisor,
  output logic [THREADS-1:0]         done,
  output logic [WIDTH-1:0]           quotient,
  output logic [WIDTH-1:0]           remainder,
  output logic                       busy,
  output logic [GW-1:0]              grant_id
);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [THREADS-1:0]   done_q, done_d;
  logic [WIDTH-1:0]     quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;

  logic                 pick_valid;
  logic [GW-1:0]        pick_idx;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic [WIDTH:0]       step_rem;
  logic [WIDTH-1:0]     step_quo;

  // Scan from lowest to highest priority so the highest-priority requester is written last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = THREADS; k >= 1; k--) begin
      if (req[(int'(last_grant_q) + k) % THREADS]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'((int'(last_grant_q) + k) % THREADS);
      end
    end
  end

  // quo_q shifts dividend bits out of its top while quotient bits enter at the bottom.
  always_comb begin
    shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dsr_q};
    step_rem = diff[WIDTH] ? shifted : diff;
    step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dsr_d        = dsr_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    done_d       = '0;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = DIVIDE;
          cnt_d        = CW'(WIDTH);
          rem_d        = '0;
          quo_d        = dividend[pick_idx*WIDTH +: WIDTH];
          dsr_d        = divisor[pick_idx*WIDTH +: WIDTH];
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
        end
      end
      DIVIDE: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d          = DONE;
          done_d[grant_q]  = 1'b1;
          quotient_d       = step_quo;
          remainder_d      = step_rem[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dsr_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= GW'(THREADS - 1);
      done_q       <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dsr_q        <= dsr_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      done_q       <= done_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_shared_div_arbiter.sv
// Directed bench for shared_div_arbiter: single ops, round-robin fairness, reset abort
// and operand isolation, each checked against hand-computed results.
module tb_shared_div_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [3:0]  done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic [1:0]  grant_id;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  shared_div_arbiter #(.THREADS(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req), .dividend(dividend), .divisor(divisor),
    .done(done), .quotient(quotient), .remainder(remainder), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int t, input logic [7:0] a, input logic [7:0] b);
    dividend[t*8 +: 8] = a;
    divisor[t*8 +: 8]  = b;
  endtask

  // Ticks until done rises; n is the number of edges taken. A timeout counts as a failure.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (done != 4'b0) return;
    end
    check("done_timeout", 32'(n), 32'(0));
  endtask

  task automatic run_one(input int t, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er);
    int n;
    set_op(t, a, b);
    req = 4'b1 << t;
    tick();
    check("single_grant", 32'(grant_id), 32'(t));
    wait_done(n);
    check("single_done", 32'(done), 32'(4'b1 << t));
    check("single_quot", 32'(quotient), 32'(eq));
    check("single_rem", 32'(remainder), 32'(er));
    $display("[TB] op t=%0d %0d/%0d -> q=%0d r=%0d", t, a, b, quotient, remainder);
    req = 4'b0;
    tick();
  endtask

  initial begin
    int n;
    int last_done_cyc;
    int busy_ok;
    logic [3:0] order_exp;

    reset    = 1'b1;
    req      = 4'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_quot", 32'(quotient), 32'(0));
    check("rst_rem", 32'(remainder), 32'(0));
    check("rst_grant", 32'(grant_id), 32'(0));

    // Thread 2: 200 / 7, with latency and busy tracked
    reset = 1'b0;
    set_op(2, 8'd200, 8'd7);
    req = 4'b0100;
    tick();
    check("t2_grant", 32'(grant_id), 32'(2));
    check("t2_busy", 32'(busy), 32'(1));
    n = 0;
    busy_ok = 1;
    while (n < 40) begin
      tick();
      n++;
      if (!busy) busy_ok = 0;
      if (done != 4'b0) break;
    end
    check("t2_latency", 32'(n), 32'(8));
    check("t2_busy_held", 32'(busy_ok), 32'(1));
    check("t2_done", 32'(done), 32'(4'b0100));
    check("t2_quot", 32'(quotient), 32'(28));
    check("t2_rem", 32'(remainder), 32'(4));
    $display("[TB] op t=2 200/7 -> q=%0d r=%0d", quotient, remainder);
    req = 4'b0;
    tick();
    check("t2_done_clear", 32'(done), 32'(0));
    check("t2_idle", 32'(busy), 32'(0));
    check("t2_quot_held", 32'(quotient), 32'(28));

    run_one(0, 8'd37, 8'd0, 8'd255, 8'd37);
    run_one(1, 8'd5, 8'd9, 8'd0, 8'd5);
    run_one(3, 8'd255, 8'd1, 8'd255, 8'd0);

    // All four requesting from reset: grants 0,1,2,3 with done pulses 10 cycles apart
    reset = 1'b1;
    set_op(0, 8'd100, 8'd3);
    set_op(1, 8'd50, 8'd5);
    set_op(2, 8'd7, 8'd2);
    set_op(3, 8'd255, 8'd16);
    req = 4'b1111;
    tick();
    reset = 1'b0;
    last_done_cyc = 0;
    for (int t = 0; t < 4; t++) begin
      wait_done(n);
      order_exp = 4'b1 << t;
      check("rr_done", 32'(done), 32'(order_exp));
      check("rr_grant", 32'(grant_id), 32'(t));
      if (t > 0) check("rr_spacing", 32'(cyc - last_done_cyc), 32'(10));
      last_done_cyc = cyc;
      case (t)
        0: begin check("rr_q0", 32'(quotient), 32'(33)); check("rr_r0", 32'(remainder), 32'(1)); end
        1: begin check("rr_q1", 32'(quotient), 32'(10)); check("rr_r1", 32'(remainder), 32'(0)); end
        2: begin check("rr_q2", 32'(quotient), 32'(3));  check("rr_r2", 32'(remainder), 32'(1)); end
        default: begin check("rr_q3", 32'(quotient), 32'(15)); check("rr_r3", 32'(remainder), 32'(15)); end
      endcase
      $display("[TB] rr t=%0d q=%0d r=%0d at cycle %0d", t, quotient, remainder, cyc);
      req[t] = 1'b0;
    end
    tick();

    // Threads 0 and 1 keep requesting: service must alternate
    set_op(0, 8'd9, 8'd4);
    set_op(1, 8'd60, 8'd7);
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      check("alt_done", 32'(done), 32'(4'b1 << (i % 2)));
      check("alt_quot", 32'(quotient), (i % 2 == 0) ? 32'd2 : 32'd8);
      check("alt_rem", 32'(remainder), (i % 2 == 0) ? 32'd1 : 32'd4);
      $display("[TB] alt #%0d done=%b q=%0d r=%0d", i, done, quotient, remainder);
    end
    req = 4'b0;
    tick();
    tick();

    // Reset during thread 1's 4th DIVIDE cycle aborts it silently
    set_op(1, 8'd77, 8'd3);
    req = 4'b0010;
    tick();
    check("abort_grant", 32'(grant_id), 32'(1));
    tick();
    tick();
    tick();
    check("abort_no_done_yet", 32'(done), 32'(0));
    reset = 1'b1;
    req   = 4'b0;
    tick();
    check("abort_done", 32'(done), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_quot", 32'(quotient), 32'(0));
    check("abort_rem", 32'(remainder), 32'(0));
    check("abort_grant_rst", 32'(grant_id), 32'(0));
    reset = 1'b0;
    set_op(0, 8'd21, 8'd4);
    req = 4'b0011;
    tick();
    check("abort_regrant", 32'(grant_id), 32'(0));
    req = 4'b0;
    wait_done(n);
    check("abort_after_done", 32'(done), 32'(4'b0001));
    check("abort_after_quot", 32'(quotient), 32'(5));
    $display("[TB] post-abort t=0 21/4 -> q=%0d r=%0d", quotient, remainder);
    tick();

    // Operands and req changed after grant must not disturb the running op
    set_op(2, 8'd100, 8'd10);
    req = 4'b0100;
    tick();
    check("iso_grant", 32'(grant_id), 32'(2));
    set_op(2, 8'd3, 8'd10);
    req = 4'b0;
    wait_done(n);
    check("iso_done", 32'(done), 32'(4'b0100));
    check("iso_quot", 32'(quotient), 32'(10));
    check("iso_rem", 32'(remainder), 32'(0));
    $display("[TB] iso t=2 100/10 -> q=%0d r=%0d", quotient, remainder);
    tick();
    check("iso_final_idle", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
